// File: rtl/bit_serial_subtractor_pkg.sv
// -----------------------------------------------------------------------------
// bit_serial_subtractor_pkg
// Shared ALU package: default operand width, adder/subtractor constants,
// the serial-subtractor FSM state encoding and a small overflow helper.
// -----------------------------------------------------------------------------
package bit_serial_subtractor_pkg;

    // Default operand/result width for the serial ALU blocks
    localparam int DEFAULT_WIDTH = 9;

    // Adder constants: neutral carry/borrow inputs
    localparam logic CARRY_IN_NONE  = 1'b0;
    localparam logic BORROW_IN_NONE = 1'b0;

    // Serial subtractor control states
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Two's-complement overflow of x - y: operand signs differ and the
    // result sign disagrees with the minuend sign.
    function automatic logic sub_ovf(input logic x_msb, input logic y_msb,
                                     input logic z_msb);
        return (x_msb ^ y_msb) & (z_msb ^ x_msb);
    endfunction

endpackage

// File: rtl/bit_serial_subtractor_fsc.sv
// -----------------------------------------------------------------------------
// fsc -- one-bit full subtractor cell computing x - y - bin.
// Ports:
//   x, y  : operand bits
//   bin   : borrow-in
//   d     : difference bit
//   bout  : borrow-out
// -----------------------------------------------------------------------------
module fsc (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    // Borrow when the minuend bit is 0 and the subtrahend bit is 1, or the
    // two bits are equal and a borrow is propagating in.
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/bit_serial_subtractor.sv
// -----------------------------------------------------------------------------
// bit_serial_subtractor -- computes x - y - bin one bit per clock, LSB first.
// A start in IDLE or DONE captures the operands; RUN lasts WIDTH cycles and
// the result flags are loaded on the edge that completes the top bit, so done
// is high exactly WIDTH+1 cycles after the start edge.
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset (wins over start)
//   start : begin a subtraction (ignored while busy)
//   x, y  : minuend / subtrahend, sampled with start
//   bin   : borrow-in, sampled with start
//   busy  : high while the subtraction is running
//   done  : one-cycle result-valid pulse
//   z     : difference modulo 2^WIDTH, held until the next result
//   bout  : borrow-out (x < y + bin, unsigned)
//   ovf   : two's-complement overflow
//   zero  : z == 0
// -----------------------------------------------------------------------------
module bit_serial_subtractor
    import bit_serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] z,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int             CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

    state_t             state_r;
    state_t             next_state_s;
    logic [WIDTH-1:0]   a_r;          // minuend, shifted right each RUN cycle
    logic [WIDTH-1:0]   b_r;          // subtrahend, shifted right each RUN cycle
    logic               borrow_r;
    logic [CW-1:0]      cnt_r;
    // Upper WIDTH-1 bits of the partially assembled difference; the bit that
    // falls off the bottom is never needed because the final shift completes
    // the word exactly.
    logic [WIDTH-2:0]   res_r;
    logic               x_msb_r;
    logic               y_msb_r;
    logic               d_s;
    logic               bout_s;
    logic               last_bit_s;
    logic [WIDTH-1:0]   z_next_s;

    fsc u_fsc (
        .x    (a_r[0]),
        .y    (b_r[0]),
        .bin  (borrow_r),
        .d    (d_s),
        .bout (bout_s)
    );

    assign last_bit_s = (cnt_r == LAST_BIT);
    assign z_next_s   = {d_s, res_r};

    // Status outputs are plain decodes of the state register
    assign busy = (state_r == RUN);
    assign done = (state_r == DONE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) next_state_s = RUN;
                else       next_state_s = IDLE;
            end
            RUN: begin
                if (last_bit_s) next_state_s = DONE;
                else            next_state_s = RUN;
            end
            DONE: begin
                if (start) next_state_s = RUN;
                else       next_state_s = IDLE;
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Operand capture, serial datapath and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r      <= {WIDTH{1'b0}};
            b_r      <= {WIDTH{1'b0}};
            borrow_r <= BORROW_IN_NONE;
            cnt_r    <= {CW{1'b0}};
            res_r    <= {(WIDTH-1){1'b0}};
            x_msb_r  <= 1'b0;
            y_msb_r  <= 1'b0;
            z        <= {WIDTH{1'b0}};
            bout     <= 1'b0;
            ovf      <= 1'b0;
            zero     <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        a_r      <= x;
                        b_r      <= y;
                        borrow_r <= bin;
                        cnt_r    <= {CW{1'b0}};
                        x_msb_r  <= x[WIDTH-1];
                        y_msb_r  <= y[WIDTH-1];
                    end
                end
                RUN: begin
                    a_r      <= {1'b0, a_r[WIDTH-1:1]};
                    b_r      <= {1'b0, b_r[WIDTH-1:1]};
                    borrow_r <= bout_s;
                    cnt_r    <= cnt_r + CW'(1);
                    res_r    <= z_next_s[WIDTH-1:1];
                    if (last_bit_s) begin
                        z    <= z_next_s;
                        bout <= bout_s;
                        ovf  <= sub_ovf(x_msb_r, y_msb_r, d_s);
                        zero <= (z_next_s == {WIDTH{1'b0}});
                    end
                end
                default: begin
                    cnt_r <= {CW{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// -----------------------------------------------------------------------------
// Scoreboard bench for bit_serial_subtractor (WIDTH = 9). Stimulus pushes the
// expected result and the cycle at which done must appear; a negedge monitor
// pops and compares whenever done is high.
// -----------------------------------------------------------------------------
module tb_bit_serial_subtractor;

    localparam int W = 9;

    typedef struct {
        logic [W-1:0] z;
        logic         bout;
        logic         ovf;
        logic         zero;
        int           due;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] z;
    logic         bout;
    logic         ovf;
    logic         zero;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   passed = 0;
    int   cyc    = 0;
    logic rst_q  = 1'b1;
    logic prev_done = 1'b0;
    logic [W+2:0] prev_out;

    bit_serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .x     (x),
        .y     (y),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .z     (z),
        .bout  (bout),
        .ovf   (ovf),
        .zero  (zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got === want) passed++;
        else $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)",
                      name, got, want, cyc);
    endtask

    // Monitor: compare each done pulse against the scoreboard head
    always @(negedge clk) begin
        if (done === 1'b1) begin
            chk("done_single_cycle", {31'd0, prev_done}, 32'd0);
            if (q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_e = q.pop_front();
                chk("z",       {23'd0, z},    {23'd0, mon_e.z});
                chk("bout",    {31'd0, bout}, {31'd0, mon_e.bout});
                chk("ovf",     {31'd0, ovf},  {31'd0, mon_e.ovf});
                chk("zero",    {31'd0, zero}, {31'd0, mon_e.zero});
                chk("latency", cyc,           mon_e.due);
            end
        end
        // Results may only change on entry to DONE or under reset
        if ({z, bout, ovf, zero} !== prev_out)
            chk("result_hold", {31'd0, (done === 1'b1) || (rst_q === 1'b1)}, 32'd1);
        prev_out  = {z, bout, ovf, zero};
        prev_done = (done === 1'b1);
    end

    function automatic exp_t model(input logic [W-1:0] xv, input logic [W-1:0] yv,
                                   input logic bv, input int due);
        exp_t e;
        int   diff;
        diff   = int'(xv) - int'(yv) - int'(bv);
        e.z    = W'(diff & 32'h1FF);
        e.bout = (int'(xv) < int'(yv) + int'(bv));
        e.ovf  = (xv[W-1] != yv[W-1]) && (e.z[W-1] != xv[W-1]);
        e.zero = (e.z == 9'd0);
        e.due  = due;
        return e;
    endfunction

    // Issue one op with hand-computed expectations; operands are scrambled
    // after the sampling edge to show later changes are ignored.
    task automatic issue(input logic [W-1:0] xv, input logic [W-1:0] yv,
                         input logic bv, input logic [W-1:0] ez,
                         input logic eb, input logic eo, input logic ezr);
        exp_t e;
        @(posedge clk); #1;
        x = xv; y = yv; bin = bv; start = 1'b1;
        e.z = ez; e.bout = eb; e.ovf = eo; e.zero = ezr; e.due = cyc + 1 + W;
        q.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        x = W'($urandom); y = W'($urandom); bin = 1'($urandom);
        repeat (W + 1) @(posedge clk);
    endtask

    initial begin
        int   busy_cnt;
        exp_t e;
        logic [W-1:0] rx, ry;
        logic rb;

        rst = 1'b1; start = 1'b0; x = 9'd0; y = 9'd0; bin = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_z",    {23'd0, z},    32'd0);
        chk("reset_flags", {29'd0, bout, ovf, zero}, 32'd0);

        // Directed vectors: x, y, bin -> z, bout, ovf, zero
        issue(9'h005, 9'h003, 1'b0, 9'h002, 1'b0, 1'b0, 1'b0);
        issue(9'h003, 9'h005, 1'b0, 9'h1FE, 1'b1, 1'b0, 1'b0);
        issue(9'h000, 9'h000, 1'b1, 9'h1FF, 1'b1, 1'b0, 1'b0);
        issue(9'h0FF, 9'h100, 1'b0, 9'h1FF, 1'b1, 1'b1, 1'b0);
        issue(9'h1AB, 9'h1AB, 1'b0, 9'h000, 1'b0, 1'b0, 1'b1);
        issue(9'h100, 9'h001, 1'b0, 9'h0FF, 1'b0, 1'b1, 1'b0);
        issue(9'h1FF, 9'h1FF, 1'b1, 9'h1FF, 1'b1, 1'b0, 1'b0);

        // Start pulsed during RUN must be ignored; busy lasts exactly W cycles
        @(posedge clk); #1;
        x = 9'd7; y = 9'd2; bin = 1'b0; start = 1'b1;
        e.z = 9'h005; e.bout = 1'b0; e.ovf = 1'b0; e.zero = 1'b0; e.due = cyc + 1 + W;
        q.push_back(e);
        @(posedge clk); #1 start = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
            if (i == 3) begin start = 1'b1; x = 9'd1; y = 9'd1; end
            if (i == 4) start = 1'b0;
        end
        chk("busy_len", busy_cnt, W);

        // Reset at RUN cycle 4 aborts the op without a done pulse
        @(posedge clk); #1;
        x = 9'h003; y = 9'h005; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_z",    {23'd0, z},    32'd0);
        chk("abort_flags", {29'd0, bout, ovf, zero}, 32'd0);
        repeat (12) @(posedge clk);

        // Normal op after the abort
        issue(9'h0A0, 9'h00F, 1'b1, 9'h090, 1'b0, 1'b0, 1'b0);

        // Back-to-back random ops with start held high through DONE
        @(posedge clk); #1;
        for (int k = 0; k < 6; k++) begin
            rx = W'($urandom); ry = W'($urandom); rb = 1'($urandom);
            x = rx; y = ry; bin = rb; start = 1'b1;
            q.push_back(model(rx, ry, rb, cyc + 1 + W));
            @(posedge clk); #1;
            x = W'($urandom); y = W'($urandom); bin = 1'($urandom);
            repeat (W) @(posedge clk);
            #1;
        end
        start = 1'b0;

        for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
        chk("queue_drained", q.size(), 32'd0);
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/bit_serial_subtractor.md
BIT_SERIAL_SUBTRACTOR -- requirements
Module: bit_serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 9, the operand/result width in bits; the only supported values are WIDTH >= 2.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1, a request to begin a subtraction; sampled on each rising edge.
REQ-005 The block SHALL have port x, input, WIDTH, the minuend; sampled with start.
REQ-006 The block SHALL have port y, input, WIDTH, the subtrahend; sampled with start.
REQ-007 The block SHALL have port bin, input, 1, the borrow-in; sampled with start.
REQ-008 The block SHALL have port busy, output, 1, high while a subtraction is in progress.
REQ-009 The block SHALL have port done, output, 1, a one-cycle result-valid pulse.
REQ-010 The block SHALL have port z, output, WIDTH, the difference x - y - bin, modulo 2^WIDTH.
REQ-011 The block SHALL have port bout, output, 1, the borrow-out: 1 iff x < y + bin (unsigned).
REQ-012 The block SHALL have port ovf, output, 1, two's-complement overflow: x[MSB] != y[MSB] and z[MSB] != x[MSB].
REQ-013 The block SHALL have port zero, output, 1, asserted iff z == 0.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-015 In IDLE or DONE, start=1 SHALL capture x, y and bin into internal shift registers, clear the bit counter, and go to RUN.
REQ-016 In RUN, each cycle SHALL process one bit, LSB first: diff = a ^ b ^ borrow; borrow_next = (~a & b) | (~(a ^ b) & borrow); diff is shifted into the result register; the counter increments.
REQ-017 RUN SHALL last exactly WIDTH cycles; on the edge completing bit WIDTH-1, the FSM SHALL go to DONE and load z, bout, ovf and zero in the same edge.
REQ-018 Latency SHALL be fixed: with start sampled at edge N, done SHALL be high during the cycle after edge N+WIDTH (9-bit: done 10 cycles after start), for exactly one cycle.
REQ-019 From DONE without start, the FSM SHALL go to IDLE.
REQ-020 busy SHALL equal (state == RUN); done SHALL equal (state == DONE); both SHALL be registered-state decodes with no combinational path from start.
REQ-021 start SHALL be ignored while in RUN; the in-flight operation and its operands SHALL be unaffected.
REQ-022 z, bout, ovf and zero SHALL hold their last result through IDLE and the whole of a following RUN, and SHALL change only on entry to DONE.
REQ-023 Changes to x, y and bin outside the start-sampling edge SHALL have no effect.

Reset
REQ-024 rst=1 at a rising edge SHALL force the state to IDLE and set busy=0, done=0, z=0, bout=0, ovf=0, zero=0, borrow=0 and counter=0, including mid-RUN, in which case the operation is aborted and no done pulse is produced.
REQ-025 rst SHALL take priority over start on the same edge.

Structure
REQ-026 The state encoding (IDLE/RUN/DONE) and the default WIDTH SHALL be defined in the shared ALU package, alongside the adder constants.
REQ-027 The one-bit datapath SHALL be a separate sub-module, fsc (full subtractor cell: inputs x, y, bin; outputs d, bout), instantiated once and reused every cycle.
REQ-028 The bit counter width SHALL be $clog2(WIDTH+1).

Verification (WIDTH=9)
REQ-029 x=5, y=3, bin=0 -> done at start+10 cycles; z=0x002, bout=0, ovf=0, zero=0.
REQ-030 x=3, y=5, bin=0 -> z=0x1FE, bout=1, ovf=0; x=0, y=0, bin=1 -> z=0x1FF, bout=1, zero=0.
REQ-031 x=0x0FF, y=0x100, bin=0 -> z=0x1FF, bout=1, ovf=1; x=0x1AB, y=0x1AB, bin=0 -> z=0, zero=1, bout=0.
REQ-032 start with x=7, y=2, then start with x=1, y=1 pulsed during RUN -> single done pulse, z=0x005; busy high for exactly 9 cycles.
REQ-033 rst asserted at RUN cycle 4 -> next cycle IDLE with all outputs 0; no done pulse; a new start afterwards completes normally.
REQ-034 Randomized back-to-back starts (start held high through DONE) -> each result matches (x - y - bin) mod 512 with correct bout/ovf/zero, one done per operation.
